arb3_rr: RTL and testbench



---
 rtl/arb3_rr.sv | 130 +++++++++++++
 tb/tb_arb3_rr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/arb3_rr.sv
// Three-way round-robin arbiter with a bounded hold quantum.
// Grant, owner and busy are all registered; the next grant is decided from req in one edge.
module arb3_rr #(
    parameter int unsigned QUANTUM = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic [1:0] owner,
    output logic       busy
);

    // Encoding matches the owner output so the state register drives it directly
    typedef enum logic [1:0] {
        S_OWN_A = 2'd0,
        S_OWN_B = 2'd1,
        S_OWN_C = 2'd2,
        S_IDLE  = 2'd3
    } state_t;

    localparam logic [3:0] QMAX = 4'(QUANTUM);

    state_t      r_state;
    logic [1:0]  r_last;
    logic [3:0]  r_cnt;
    logic [2:0]  r_gnt;
    logic        r_busy;

    state_t      w_state_nxt;
    logic [1:0]  w_last_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [2:0]  w_gnt_nxt;
    logic [2:0]  w_own_oh;
    logic [2:0]  w_excl;
    logic [2:0]  w_cand;
    logic        w_search;
    logic [1:0]  w_idx1;
    logic [1:0]  w_idx2;
    logic [1:0]  w_win;
    logic        w_found;

    always_comb begin
        w_own_oh = 3'b000;
        case (r_state)
            S_OWN_A: w_own_oh = 3'b001;
            S_OWN_B: w_own_oh = 3'b010;
            S_OWN_C: w_own_oh = 3'b100;
            default: w_own_oh = 3'b000;
        endcase
    end

    // Search order (last+1), (last+2), last, all mod 3
    always_comb begin
        w_idx1  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
        w_idx2  = (r_last == 2'd0) ? 2'd2 : r_last - 2'd1;
        w_cand  = req & ~w_excl;
        w_win   = r_last;
        w_found = 1'b1;
        if (w_cand[w_idx1]) begin
            w_win = w_idx1;
        end else if (w_cand[w_idx2]) begin
            w_win = w_idx2;
        end else if (w_cand[r_last]) begin
            w_win = r_last;
        end else begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_search    = 1'b0;
        w_excl      = 3'b000;
        if (r_state == S_IDLE) begin
            w_search = |req;
        end else if (!(|(req & w_own_oh))) begin
            w_search = 1'b1;
            w_excl   = w_own_oh;
        end else if (r_cnt < QMAX) begin
            w_cnt_nxt = r_cnt + 4'd1;
        end else if (|(req & ~w_own_oh)) begin
            w_search = 1'b1;
            w_excl   = w_own_oh;
        end
        if (w_search) begin
            if (w_found) begin
                w_state_nxt = state_t'(w_win);
                w_last_nxt  = w_win;
                w_cnt_nxt   = 4'd1;
            end else begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        end
    end

    always_comb begin
        w_gnt_nxt = 3'b000;
        case (w_state_nxt)
            S_OWN_A: w_gnt_nxt = 3'b001;
            S_OWN_B: w_gnt_nxt = 3'b010;
            S_OWN_C: w_gnt_nxt = 3'b100;
            default: w_gnt_nxt = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_last  <= 2'd2;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    assign gnt   = r_gnt;
    assign owner = r_state;
    assign busy  = r_busy;

endmodule

// File: tb/tb_arb3_rr.sv
// Randomised and directed checks of arb3_rr against a behavioural round-robin model.
module tb_arb3_rr;

    localparam int unsigned Q = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] owner;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner index (3 = none), last-served pointer, hold count
    int m_own;
    int m_last;
    int m_cnt;
    int wait_c [3];
    logic [2:0] prev_req;
    logic       prev_rst;

    arb3_rr #(.QUANTUM(Q)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pick first requester in rotating order from m_last, skipping excl (-1 = none)
    function automatic int pick(input logic [2:0] r, input int last, input int excl);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (last + k) % 3;
            if (r[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        bit do_pick;
        int excl;
        do_pick = 0;
        excl    = -1;
        if (reset) begin
            m_own = 3; m_last = 2; m_cnt = 0;
        end else begin
            if (m_own == 3) begin
                do_pick = (req != 3'b000);
            end else if (!req[m_own]) begin
                do_pick = 1; excl = m_own;
            end else if (m_cnt < int'(Q)) begin
                m_cnt++;
            end else if (pick(req, m_last, m_own) >= 0) begin
                do_pick = 1; excl = m_own;
            end
            if (do_pick) begin
                w = pick(req, m_last, excl);
                if (w >= 0) begin
                    m_own = w; m_last = w; m_cnt = 1;
                end else begin
                    m_own = 3; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic tick();
        logic [2:0] exp_gnt;
        model_step();
        prev_req = req;
        prev_rst = reset;
        @(posedge clk);
        #1;
        exp_gnt = (m_own == 3) ? 3'b000 : 3'(1 << m_own);
        check_eq("gnt", gnt, exp_gnt);
        check_eq("owner", owner, m_own);
        check_eq("busy", busy, m_own != 3);
        check_eq("nonreq_grant", gnt & ~prev_req, 3'b000);
        check_eq("owner_gnt_cons", (owner == 2'd3) ? (gnt == 3'b000) : (gnt[owner] && $countones(gnt) == 1), 1);
        for (int i = 0; i < 3; i++) begin
            if (prev_rst || !prev_req[i] || gnt[i]) begin
                wait_c[i] = 0;
            end else begin
                wait_c[i]++;
                check_eq("starve", wait_c[i] <= int'(2 * Q + 1), 1);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        m_own = 3; m_last = 2; m_cnt = 0;
        for (int i = 0; i < 3; i++) wait_c[i] = 0;
        reset = 1'b1;
        req   = 3'b000;
        tick();
        tick();
        check_eq("rst_gnt", gnt, 3'b000);
        check_eq("rst_owner", owner, 2'd3);
        check_eq("rst_busy", busy, 1'b0);

        // Single requester holds indefinitely, then saturated holder yields at once
        reset = 1'b0;
        req   = 3'b010;
        tick();
        check_eq("b_grant", gnt, 3'b010);
        check_eq("b_owner", owner, 2'd1);
        for (int k = 0; k < 8; k++) tick();
        check_eq("b_hold", gnt, 3'b010);
        req = 3'b111;
        tick();
        check_eq("sat_preempt", gnt, 3'b100);

        // All requesting: Q cycles each in order a, b, c
        do_reset();
        req = 3'b111;
        for (int k = 0; k < 16; k++) begin
            logic [1:0] exp_own;
            tick();
            exp_own = 2'((k / int'(Q)) % 3);
            check_eq("rr_seq", owner, exp_own);
        end

        // Early release hands over without a gap, then idle
        do_reset();
        req = 3'b101;
        tick();
        check_eq("a_first", gnt, 3'b001);
        tick();
        req = 3'b100;
        tick();
        check_eq("handover_c", gnt, 3'b100);
        req = 3'b000;
        tick();
        check_eq("release_idle_gnt", gnt, 3'b000);
        check_eq("release_idle_own", owner, 2'd3);
        req = 3'b111;
        tick();
        check_eq("rotated_to_a", gnt, 3'b001);

        // Reset drops an active grant
        do_reset();
        req = 3'b010;
        tick();
        req = 3'b111;
        reset = 1'b1;
        tick();
        check_eq("rst_drop_gnt", gnt, 3'b000);
        check_eq("rst_drop_own", owner, 2'd3);
        check_eq("rst_drop_busy", busy, 1'b0);
        reset = 1'b0;
        tick();
        check_eq("post_rst_a", gnt, 3'b001);

        // Random sticky requests with rare resets
        for (int k = 0; k < 10000; k++) begin
            logic [2:0] flip;
            flip = 3'b000;
            for (int i = 0; i < 3; i++) flip[i] = ($urandom_range(0, 3) == 0);
            req   = req ^ flip;
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
